// File: rtl/com_divider_scheduler.sv
// Shares one divider core across every colour channel. At each frame boundary it snapshots the totals,
// runs the x/y divisions in order, clamps the quotients and publishes all centers in one commit cycle.
module com_divider_scheduler #(
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned X_MAX   = 639,
  parameter int unsigned Y_MAX   = 479,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_done,
  input  logic [NUM_CH*32-1:0] x_total,
  input  logic [NUM_CH*32-1:0] y_total,
  input  logic [NUM_CH*26-1:0] mass_total,
  output logic [31:0]          div_dividend,
  output logic [25:0]          div_divisor,
  output logic                 div_nd,
  input  logic                 div_rfd,
  input  logic [31:0]          div_quotient,
  input  logic                 div_rdy,
  output logic [NUM_CH*10-1:0] x_center,
  output logic [NUM_CH*10-1:0] y_center,
  output logic [NUM_CH-1:0]    center_valid,
  output logic                 centers_updated,
  output logic                 busy,
  output logic                 overrun,
  output logic                 div_error
);

  localparam int unsigned NUM_JOBS = 2 * NUM_CH;
  localparam int unsigned JOB_W    = (NUM_JOBS > 1) ? $clog2(NUM_JOBS) : 1;
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;

  state_t            state, stateNext;
  logic [JOB_W-1:0]  job;
  logic [CNT_W-1:0]  waitCnt;
  logic [CH_W-1:0]   ch;
  logic              axis;
  logic              lastJob;
  logic              skip, capture, advance, timedOut;
  logic [9:0]        qClamp;

  logic [31:0]       xShadow [NUM_CH];
  logic [31:0]       yShadow [NUM_CH];
  logic [25:0]       mShadow [NUM_CH];
  logic [9:0]        scrX    [NUM_CH];
  logic [9:0]        scrY    [NUM_CH];
  logic [NUM_CH-1:0] scrValid;
  logic [9:0]        xCommit [NUM_CH];
  logic [9:0]        yCommit [NUM_CH];

  assign ch      = CH_W'(job >> 1);
  assign axis    = job[0];
  assign lastJob = (job == JOB_W'(NUM_JOBS - 1));

  // Operands come straight from the shadow registers, so they stay put for as long as the job index does.
  assign div_dividend = axis ? yShadow[ch] : xShadow[ch];
  assign div_divisor  = mShadow[ch];

  assign busy            = (state != IDLE);
  assign overrun         = frame_done && (state != IDLE);
  assign centers_updated = (state == COMMIT);
  assign div_error       = timedOut;

  always_comb begin
    if (axis) qClamp = (div_quotient > 32'(Y_MAX)) ? 10'(Y_MAX) : div_quotient[9:0];
    else      qClamp = (div_quotient > 32'(X_MAX)) ? 10'(X_MAX) : div_quotient[9:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    div_nd    = 1'b0;
    skip      = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    timedOut  = 1'b0;
    case (state)
      IDLE:   if (frame_done) stateNext = ISSUE;
      ISSUE: begin
        if (mShadow[ch] == '0) begin
          skip    = 1'b1;
          advance = 1'b1;
        end else if (div_rfd) begin
          div_nd    = 1'b1;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (div_rdy) begin
          capture = 1'b1;
          advance = 1'b1;
        end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
          timedOut  = 1'b1;
          stateNext = IDLE;
        end
      end
      COMMIT: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (advance) stateNext = lastJob ? COMMIT : ISSUE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      job          <= '0;
      waitCnt      <= '0;
      scrValid     <= '0;
      center_valid <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        xShadow[c] <= '0;
        yShadow[c] <= '0;
        mShadow[c] <= '0;
        scrX[c]    <= '0;
        scrY[c]    <= '0;
        xCommit[c] <= '0;
        yCommit[c] <= '0;
      end
    end else begin
      if (state == IDLE && frame_done) begin
        job <= '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          xShadow[c] <= x_total[c*32 +: 32];
          yShadow[c] <= y_total[c*32 +: 32];
          mShadow[c] <= mass_total[c*26 +: 26];
        end
      end

      if (div_nd)             waitCnt <= '0;
      else if (state == WAIT) waitCnt <= waitCnt + CNT_W'(1);

      // A massless channel re-publishes its previous center but is flagged invalid.
      if (skip) begin
        if (axis) scrY[ch] <= yCommit[ch];
        else      scrX[ch] <= xCommit[ch];
        scrValid[ch] <= 1'b0;
      end

      if (capture) begin
        if (axis) scrY[ch] <= qClamp;
        else      scrX[ch] <= qClamp;
        scrValid[ch] <= 1'b1;
      end

      if (advance && !lastJob) job <= job + JOB_W'(1);

      if (timedOut) scrValid <= '0;

      if (state == COMMIT) begin
        center_valid <= scrValid;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          xCommit[c] <= scrX[c];
          yCommit[c] <= scrY[c];
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign x_center[c*10 +: 10] = xCommit[c];
    assign y_center[c*10 +: 10] = yCommit[c];
  end

endmodule

// File: tb/tb_com_divider_scheduler.sv
// Randomised self-checking bench for com_divider_scheduler: a latency-programmable divider model
// drives the DUT while a frame-level reference model predicts operands, timing and committed centers.
module tb_com_divider_scheduler;

  logic        clk = 1'b0;
  logic        reset, frame_done, div_rfd, div_rdy;
  logic [95:0] x_total, y_total;
  logic [77:0] mass_total;
  logic [31:0] div_dividend, div_quotient;
  logic [25:0] div_divisor;
  logic        div_nd, centers_updated, busy, overrun, div_error;
  logic [29:0] x_center, y_center;
  logic [2:0]  center_valid;

  com_divider_scheduler #(.NUM_CH(3), .X_MAX(639), .Y_MAX(479), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .frame_done(frame_done),
    .x_total(x_total), .y_total(y_total), .mass_total(mass_total),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_nd(div_nd),
    .div_rfd(div_rfd), .div_quotient(div_quotient), .div_rdy(div_rdy),
    .x_center(x_center), .y_center(y_center), .center_valid(center_valid),
    .centers_updated(centers_updated), .busy(busy), .overrun(overrun), .div_error(div_error)
  );

  always #5 clk = ~clk;

  int nTests = 0, nFail = 0;
  int lat = 5;
  bit noResp = 0;
  int cyc = 0;
  int ndCount, updCount, ovrCount, errCount, updCyc, errCyc, ndCyc, fdCyc;
  logic [57:0] opsSeen[$];
  logic [57:0] expOps[$];
  int unsigned expX[3], expY[3];
  logic [2:0]  expValid;
  int unsigned curX[3], curY[3], curM[3];
  int          expCycles;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (div_nd === 1'b1) begin
      ndCount++;
      ndCyc = cyc;
      opsSeen.push_back({div_dividend, div_divisor});
    end
    if (centers_updated === 1'b1) begin updCount++; updCyc = cyc; end
    if (overrun === 1'b1) ovrCount++;
    if (div_error === 1'b1) begin errCount++; errCyc = cyc; end
    if (frame_done && !busy && !reset) fdCyc = cyc;
  end

  // Divider model: div_rdy pulses exactly lat cycles after the cycle carrying div_nd.
  initial begin
    logic [31:0] q;
    div_rdy = 1'b0;
    div_quotient = '0;
    forever begin
      @(negedge clk);
      if (div_nd === 1'b1 && !noResp) begin
        q = div_dividend / 32'(div_divisor);
        repeat (lat) @(posedge clk);
        #1 div_rdy = 1'b1; div_quotient = q;
        @(posedge clk);
        #1 div_rdy = 1'b0; div_quotient = $urandom;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [29:0] packC(input bit yAxis);
    logic [29:0] v;
    for (int c = 0; c < 3; c++) v[c*10 +: 10] = yAxis ? 10'(expY[c]) : 10'(expX[c]);
    return v;
  endfunction

  task automatic clear_counts();
    ndCount = 0; updCount = 0; ovrCount = 0; errCount = 0;
    updCyc = -1; errCyc = -1; ndCyc = -1; fdCyc = -1;
    opsSeen.delete();
  endtask

  task automatic set_ch(input int c, input int unsigned xt, input int unsigned yt, input int unsigned m);
    curX[c] = xt; curY[c] = yt; curM[c] = m;
    x_total[c*32 +: 32]    = xt;
    y_total[c*32 +: 32]    = yt;
    mass_total[c*26 +: 26] = 26'(m);
  endtask

  // Reference: predicted operand stream, frame duration and committed centers for the current totals.
  task automatic expect_frame();
    int unsigned q;
    expOps.delete();
    expCycles = 1;
    for (int c = 0; c < 3; c++) begin
      if (curM[c] == 0) begin
        expValid[c] = 1'b0;
        expCycles += 2;
      end else begin
        q = curX[c] / curM[c];
        expX[c] = (q > 639) ? 639 : q;
        q = curY[c] / curM[c];
        expY[c] = (q > 479) ? 479 : q;
        expValid[c] = 1'b1;
        expOps.push_back({32'(curX[c]), 26'(curM[c])});
        expOps.push_back({32'(curY[c]), 26'(curM[c])});
        expCycles += 2 * (lat + 1);
      end
    end
  endtask

  task automatic pulse_frame();
    @(posedge clk);
    #1 frame_done = 1'b1;
    @(posedge clk);
    #1 frame_done = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (updCount != 0 || errCount != 0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_done = 1'b0; div_rfd = 1'b1;
    x_total = '0; y_total = '0; mass_total = '0;
    for (int c = 0; c < 3; c++) begin expX[c] = 0; expY[c] = 0; end
    expValid = '0;
    repeat (3) @(posedge clk);
    #1;
    nTests++;
    if ({x_center, y_center, center_valid} !== '0) begin
      nFail++; $display("FAIL reset_centers: got %h/%h/%b want 0", x_center, y_center, center_valid);
    end
    nTests++;
    if ({div_nd, centers_updated, busy, overrun, div_error} !== 5'b0) begin
      nFail++; $display("FAIL reset_strobes: got %b want 00000", {div_nd, centers_updated, busy, overrun, div_error});
    end
    nTests++;
    if ({div_dividend, div_divisor} !== '0) begin
      nFail++; $display("FAIL reset_operands: got %h/%h want 0", div_dividend, div_divisor);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_and_check(input string tag, input bit checkOps);
    bit ok, same;
    expect_frame();
    pulse_frame();
    wait_done(2000, ok);
    nTests++;
    if (!ok || updCount != 1) begin
      nFail++; $display("FAIL %s_commit: got updates=%0d done=%0d want 1 update", tag, updCount, ok);
    end
    nTests++;
    if (updCyc - fdCyc != expCycles) begin
      nFail++; $display("FAIL %s_latency: got %0d want %0d", tag, updCyc - fdCyc, expCycles);
    end
    if (checkOps) begin
      same = (opsSeen.size() == expOps.size());
      if (same) foreach (expOps[i]) if (opsSeen[i] !== expOps[i]) same = 0;
      nTests++;
      if (!same) begin
        nFail++; $display("FAIL %s_ops: got %0d strobes want %0d in job order", tag, opsSeen.size(), expOps.size());
      end
    end
    nTests++;
    if (x_center !== packC(0) || y_center !== packC(1) || center_valid !== expValid) begin
      nFail++; $display("FAIL %s_centers: got %h/%h/%b want %h/%h/%b", tag,
                        x_center, y_center, center_valid, packC(0), packC(1), expValid);
    end
  endtask

  task automatic test_basic();
    clear_counts(); lat = 5;
    for (int c = 0; c < 3; c++) set_ch(c, 3200, 1600, 10);
    run_and_check("basic", 1);
    nTests++;
    if (x_center[9:0] !== 10'd320 || y_center[9:0] !== 10'd160 || center_valid !== 3'b111 || ndCount != 6) begin
      nFail++; $display("FAIL basic_values: got %0d,%0d v=%b nd=%0d want 320,160 v=111 nd=6",
                        x_center[9:0], y_center[9:0], center_valid, ndCount);
    end
    repeat (2) @(posedge clk);
    #1;
    nTests++;
    if (busy !== 1'b0 || updCount != 1) begin
      nFail++; $display("FAIL basic_idle: got busy=%b updates=%0d want 0 and 1", busy, updCount);
    end
  endtask

  task automatic test_zero_mass();
    clear_counts(); lat = 3;
    set_ch(0, 5000, 2500, 25); set_ch(1, 1000, 500, 10); set_ch(2, 7777, 3333, 77);
    run_and_check("zm_prior", 1);
    clear_counts();
    set_ch(0, 9000, 4000, 30); set_ch(1, 123456, 654321, 0); set_ch(2, 2000, 1000, 20);
    run_and_check("zero_mass", 1);
    nTests++;
    if (x_center[19:10] !== 10'd100 || y_center[19:10] !== 10'd50 || center_valid[1] !== 1'b0 || ndCount != 4) begin
      nFail++; $display("FAIL zero_mass_hold: got %0d,%0d v1=%b nd=%0d want 100,50 v1=0 nd=4",
                        x_center[19:10], y_center[19:10], center_valid[1], ndCount);
    end
  endtask

  task automatic test_clamp();
    clear_counts(); lat = 2;
    set_ch(0, 6399, 4790, 10);
    set_ch(1, 6400, 4800, 10);
    set_ch(2, 100000, 90000, 10);
    run_and_check("clamp", 1);
    nTests++;
    if (x_center[29:20] !== 10'd639 || y_center[29:20] !== 10'd479) begin
      nFail++; $display("FAIL clamp_ch2: got %0d,%0d want 639,479", x_center[29:20], y_center[29:20]);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    clear_counts(); lat = 4;
    set_ch(0, 4400, 2200, 11); set_ch(1, 3000, 900, 15); set_ch(2, 800, 600, 4);
    expect_frame();
    pulse_frame();
    @(posedge clk);
    #1 frame_done = 1'b1;
    set_ch(0, 1, 1, 1); set_ch(1, 2, 2, 1); set_ch(2, 3, 3, 1);
    @(posedge clk);
    #1 frame_done = 1'b0;
    wait_done(2000, ok);
    nTests++;
    if (ovrCount != 1) begin
      nFail++; $display("FAIL overrun_pulse: got %0d pulses want 1", ovrCount);
    end
    nTests++;
    if (!ok || updCount != 1 || x_center !== packC(0) || y_center !== packC(1) || center_valid !== expValid) begin
      nFail++; $display("FAIL overrun_result: got %h/%h/%b upd=%0d want %h/%h/%b upd=1",
                        x_center, y_center, center_valid, updCount, packC(0), packC(1), expValid);
    end
  endtask

  task automatic test_rfd();
    clear_counts(); lat = 5;
    set_ch(0, 12345, 6789, 50); set_ch(1, 2222, 1111, 11); set_ch(2, 640, 480, 2);
    div_rfd = 1'b0;
    expect_frame();
    pulse_frame();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nTests++;
      if (div_nd !== 1'b0 || div_dividend !== 32'd12345 || div_divisor !== 26'd50) begin
        nFail++; $display("FAIL rfd_hold_%0d: got nd=%b %0d/%0d want nd=0 12345/50", i, div_nd, div_dividend, div_divisor);
      end
      @(posedge clk);
      #1;
    end
    div_rfd = 1'b1;
    repeat (2) @(negedge clk);
    nTests++;
    if (ndCount != 1 || div_dividend !== 32'd12345 || div_divisor !== 26'd50) begin
      nFail++; $display("FAIL rfd_wait_operands: got nd=%0d %0d/%0d want nd=1 12345/50", ndCount, div_dividend, div_divisor);
    end
    begin
      bit ok;
      wait_done(2000, ok);
      nTests++;
      if (!ok || x_center !== packC(0) || y_center !== packC(1) || center_valid !== expValid) begin
        nFail++; $display("FAIL rfd_result: got %h/%h/%b want %h/%h/%b",
                          x_center, y_center, center_valid, packC(0), packC(1), expValid);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [29:0] px, py;
    logic [2:0]  pv;
    clear_counts(); noResp = 1;
    px = x_center; py = y_center; pv = center_valid;
    set_ch(0, 99999, 88888, 33); set_ch(1, 500, 500, 5); set_ch(2, 700, 700, 7);
    pulse_frame();
    wait_done(600, ok);
    repeat (3) @(posedge clk);
    #1;
    nTests++;
    if (!ok || errCount != 1 || errCyc - ndCyc != 255) begin
      nFail++; $display("FAIL timeout_error: got pulses=%0d after %0d cycles want 1 after 255", errCount, errCyc - ndCyc);
    end
    nTests++;
    if (updCount != 0 || busy !== 1'b0 || x_center !== px || y_center !== py || center_valid !== pv) begin
      nFail++; $display("FAIL timeout_hold: got upd=%0d busy=%b %h/%h/%b want upd=0 busy=0 %h/%h/%b",
                        updCount, busy, x_center, y_center, center_valid, px, py, pv);
    end
    noResp = 0;
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      clear_counts();
      lat = $urandom_range(1, 6);
      for (int c = 0; c < 3; c++) begin
        int unsigned m;
        m = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 5000);
        if ($urandom_range(0, 3) == 0)
          set_ch(c, $urandom, $urandom, m);
        else
          set_ch(c, m * $urandom_range(0, 800), m * $urandom_range(0, 600) + $urandom_range(0, 9), m);
      end
      run_and_check($sformatf("rand%0d", f), 1);
    end
  endtask

  task automatic test_reset_wait();
    bit seen;
    clear_counts(); lat = 5;
    set_ch(0, 3000, 2000, 10); set_ch(1, 3000, 2000, 10); set_ch(2, 3000, 2000, 10);
    pulse_frame();
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ndCount >= 3) begin seen = 1; break; end
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    nTests++;
    if (!seen || {x_center, y_center, center_valid, div_nd, busy, centers_updated, div_error} !== '0
        || {div_dividend, div_divisor} !== '0) begin
      nFail++; $display("FAIL reset_mid_wait: got %h/%h/%b busy=%b ops=%h/%h want all 0",
                        x_center, y_center, center_valid, busy, div_dividend, div_divisor);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    nTests++;
    if (updCount != 0 || busy !== 1'b0 || {x_center, y_center, center_valid} !== '0) begin
      nFail++; $display("FAIL reset_no_commit: got upd=%0d busy=%b %h/%h/%b want 0 and cleared",
                        updCount, busy, x_center, y_center, center_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_mass();
    test_clamp();
    test_overrun();
    test_rfd();
    test_timeout();
    test_random();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
